// File: rtl/data_mem_ctrl.sv
// Load/store data memory controller: a data region growing up from DATA_BASE and a stack region growing down from STACK_TOP.
// Optional macro FAULT_CAPTURE_EN adds fault_addr/fault_seen, which record the first faulting access after reset.
module data_mem_ctrl #(
  parameter logic [31:0] DATA_BASE   = 32'h0000_1000,
  parameter int          DATA_WORDS  = 100,
  parameter logic [31:0] STACK_TOP   = 32'hFFFF_FFFC,
  parameter int          STACK_WORDS = 10,
  parameter int          READ_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic        init_done
`ifdef FAULT_CAPTURE_EN
  ,
  output logic [31:0] fault_addr,
  output logic        fault_seen
`endif
);

  localparam logic [1:0] S_INIT = 2'd0;
  localparam logic [1:0] S_IDLE = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam int SWEEP = (DATA_WORDS > STACK_WORDS) ? DATA_WORDS : STACK_WORDS;
  localparam int SW_W  = $clog2(SWEEP + 1);
  localparam int DI_W  = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;
  localparam int SI_W  = (STACK_WORDS > 1) ? $clog2(STACK_WORDS) : 1;

  localparam logic [SW_W-1:0] SWEEP_LAST = SW_W'(SWEEP - 1);
  localparam logic [SW_W-1:0] DATA_CNT   = SW_W'(DATA_WORDS);
  localparam logic [SW_W-1:0] STACK_CNT  = SW_W'(STACK_WORDS);
  localparam logic [29:0]     DBASE_W    = DATA_BASE[31:2];
  localparam logic [29:0]     STOP_W     = STACK_TOP[31:2];
  localparam logic [29:0]     DWORDS_W   = 30'(DATA_WORDS);
  localparam logic [29:0]     SWORDS_W   = 30'(STACK_WORDS);
  localparam logic [1:0]      WAIT_LAST  = 2'(READ_LAT - 2);

  typedef struct packed {
    logic            data_hit;
    logic            stack_hit;
    logic            fault;
    logic [DI_W-1:0] didx;
    logic [SI_W-1:0] sidx;
  } dec_t;

  // Word-address decode; offsets are computed in 30 bits so region ends near 2^32 cannot wrap.
  function automatic dec_t decode(input logic [31:0] addr, input logic [1:0] size);
    dec_t        d;
    logic [29:0] doff;
    logic [29:0] soff;
    logic        misal;
    doff        = addr[31:2] - DBASE_W;
    soff        = STOP_W - addr[31:2];
    d.data_hit  = (addr[31:2] >= DBASE_W) && (doff < DWORDS_W);
    d.stack_hit = !d.data_hit && (addr[31:2] <= STOP_W) && (soff < SWORDS_W);
    d.didx      = doff[DI_W-1:0];
    d.sidx      = soff[SI_W-1:0];
    case (size)
      2'b00:   misal = 1'b0;
      2'b01:   misal = addr[0];
      2'b10:   misal = |addr[1:0];
      default: misal = 1'b1;
    endcase
    d.fault = misal || !(d.data_hit || d.stack_hit);
    return d;
  endfunction

  logic [1:0]      state;
  logic [SW_W-1:0] sweep_idx;
  logic [1:0]      lat_cnt;
  logic            done_q;
  logic            r_we;
  logic [1:0]      r_size;
  logic            r_unsigned;
  logic [31:0]     r_addr;
  logic [31:0]     rdata_q;
  logic            fault_q;

  logic [31:0] data_mem  [DATA_WORDS];
  logic [31:0] stack_mem [STACK_WORDS];

  dec_t        w_dec;
  dec_t        r_dec;
  logic        accept;
  logic        commit;
  logic [3:0]  be;
  logic [31:0] wlanes;
  logic [31:0] rword;
  logic [31:0] shifted;
  logic [31:0] resp_word;

  assign w_dec  = decode(req_addr, req_size);
  assign r_dec  = decode(r_addr, r_size);
  assign accept = req_valid && req_ready;
  assign commit = accept && req_we && !w_dec.fault;

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    be     = 4'b0000;
    wlanes = req_wdata;
    case (req_size)
      2'b00: begin
        be     = 4'b0001 << req_addr[1:0];
        wlanes = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be     = req_addr[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{req_wdata[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // NOTE: the arrays have no reset; the INIT sweep clears them so they can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (state == S_INIT) begin
      if (sweep_idx < DATA_CNT)  data_mem[sweep_idx[DI_W-1:0]]  <= '0;
      if (sweep_idx < STACK_CNT) stack_mem[sweep_idx[SI_W-1:0]] <= '0;
    end else if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          if (w_dec.data_hit)       data_mem[w_dec.didx][8*i +: 8]  <= wlanes[8*i +: 8];
          else if (w_dec.stack_hit) stack_mem[w_dec.sidx][8*i +: 8] <= wlanes[8*i +: 8];
        end
      end
    end
  end

  // Read path depends only on the registered request, never on the live bus.
  always_comb begin
    rword     = r_dec.data_hit ? data_mem[r_dec.didx] :
                (r_dec.stack_hit ? stack_mem[r_dec.sidx] : '0);
    shifted   = rword >> {r_addr[1:0], 3'b000};
    resp_word = shifted;
    if (r_dec.fault)  resp_word = 32'hFFFF_FFFF;
    else if (r_we)    resp_word = '0;
    else if (r_size == 2'b00)
      resp_word = r_unsigned ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
    else if (r_size == 2'b01)
      resp_word = r_unsigned ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_INIT;
      sweep_idx  <= '0;
      lat_cnt    <= '0;
      done_q     <= 1'b0;
      r_we       <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      rdata_q    <= '0;
      fault_q    <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          if (sweep_idx == SWEEP_LAST) begin
            state  <= S_IDLE;
            done_q <= 1'b1;
          end else begin
            sweep_idx <= sweep_idx + SW_W'(1);
          end
        end
        S_IDLE: begin
          if (req_valid) begin
            r_we       <= req_we;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_addr     <= req_addr;
            lat_cnt    <= '0;
            state      <= (req_we || READ_LAT == 1) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (lat_cnt == WAIT_LAST) state <= S_RESP;
          else                      lat_cnt <= lat_cnt + 2'd1;
        end
        default: begin
          rdata_q <= resp_word;
          fault_q <= r_dec.fault;
          state   <= S_IDLE;
        end
      endcase
    end
  end

`ifdef FAULT_CAPTURE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_addr <= '0;
      fault_seen <= 1'b0;
    end else if (state == S_RESP && r_dec.fault && !fault_seen) begin
      fault_addr <= r_addr;
      fault_seen <= 1'b1;
    end
  end
`endif

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign rsp_rdata = rsp_valid ? resp_word : rdata_q;
  assign rsp_fault = rsp_valid ? r_dec.fault : fault_q;
  assign init_done = done_q;

endmodule
